entropy_pkt_scheduler: RTL and testbench

//  Sequences packets of one batch through the entropy datapath (BRAM -> byte counter -> entropy calc).

---
 rtl/entropy_pkg.sv | 23 ++
 rtl/bram_rd_align.sv | 27 ++
 rtl/entropy_pkt_scheduler.sv | 148 ++++++++++++++
 tb/tb_entropy_pkt_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/entropy_pkg.sv
// Shared types and constants for the entropy packet datapath.
// Read tags travel beside BRAM reads so each data beat meets its metadata.
package entropy_pkg;

   localparam int WORD_BYTES = 8;
   localparam int LEN_W      = 8;
   localparam int FLOW_W     = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic              valid;
      logic [LEN_W-1:0]  len;
      logic              last;
      logic [FLOW_W-1:0] flow;
   } rd_tag_t;

endpackage

// File: rtl/bram_rd_align.sv
// Delays the beat tag by the BRAM read latency.
// The tag then emerges on the same cycle as the matching read data.
module bram_rd_align
   import entropy_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic    clk,
   input  logic    rst,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);

   rd_tag_t pipe [RD_LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= tag_in;
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign tag_out = pipe[RD_LAT-1];

endmodule

// File: rtl/entropy_pkt_scheduler.sv
// Batch packet scheduler: takes descriptors, reads packet words from BRAM and streams beats
// to the byte counter, limited by credits that come back with each entropy result.
module entropy_pkt_scheduler
   import entropy_pkg::*;
#(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 16,
   parameter int RD_LAT       = 1,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_batch_start,
   input  logic [15:0]           i_batch_pkts,
   input  logic                  i_desc_valid,
   output logic                  o_desc_ready,
   input  logic [ADDR_WIDTH-1:0] i_desc_addr,
   input  logic [LEN_W-1:0]      i_desc_len,
   input  logic [FLOW_W-1:0]     i_desc_flow,
   output logic                  o_bram_en,
   output logic [ADDR_WIDTH-1:0] o_bram_addr,
   input  logic [DATA_WIDTH-1:0] i_bram_dout,
   output logic [DATA_WIDTH-1:0] o_count_data,
   output logic                  o_count_data_valid,
   output logic [LEN_W-1:0]      o_count_data_len,
   output logic                  o_count_data_last,
   output logic [FLOW_W-1:0]     o_flow_num,
   input  logic                  i_result_valid,
   output logic [3:0]            o_inflight,
   output logic                  o_batch_done,
   output logic                  o_err
);

   localparam logic [3:0]       MAX_IF = 4'(MAX_INFLIGHT);
   localparam logic [LEN_W-1:0] WB     = LEN_W'(WORD_BYTES);

   state_t                state;
   logic [15:0]           pkts;
   logic [15:0]           issued;
   logic [15:0]           retired;
   logic [3:0]            inflight;
   logic                  err;
   logic                  batch_done;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [LEN_W-1:0]      rem_len;
   logic [FLOW_W-1:0]     cur_flow;

   logic             hs;
   logic             zero_hs;
   logic             take;
   logic             result_ok;
   logic             beat_last;
   logic [LEN_W-1:0] beat_len;
   rd_tag_t          tag_in;
   rd_tag_t          tag_out;

   assign o_desc_ready = (state == ARMED) && (inflight < MAX_IF) && (issued < pkts);
   assign hs        = o_desc_ready && i_desc_valid;
   assign zero_hs   = hs && (i_desc_len == '0);
   assign take      = hs && (i_desc_len != '0);
   assign result_ok = i_result_valid && (inflight != 4'd0);

   // rem_len holds the bytes still to be read, so the final beat carries the remainder.
   assign beat_last = (rem_len <= WB);
   assign beat_len  = beat_last ? rem_len : WB;

   always_comb begin
      tag_in = '0;
      if (state == READ) begin
         tag_in.valid = 1'b1;
         tag_in.len   = beat_len;
         tag_in.last  = beat_last;
         tag_in.flow  = cur_flow;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         pkts       <= '0;
         issued     <= '0;
         retired    <= '0;
         inflight   <= '0;
         err        <= 1'b0;
         batch_done <= 1'b0;
         cur_addr   <= '0;
         rem_len    <= '0;
         cur_flow   <= '0;
      end else begin
         batch_done <= 1'b0;
         if ((i_result_valid && inflight == 4'd0) || zero_hs) err <= 1'b1;
         // A zero-length descriptor retires on the spot and never takes a credit.
         inflight <= inflight + 4'(take) - 4'(result_ok);
         retired  <= retired + 16'(result_ok) + 16'(zero_hs);
         issued   <= issued + 16'(hs);

         case (state)
            IDLE: begin
               if (i_batch_start) begin
                  pkts    <= i_batch_pkts;
                  issued  <= '0;
                  retired <= '0;
                  state   <= (i_batch_pkts == '0) ? DONE : ARMED;
               end
            end
            ARMED: begin
               if (retired == pkts) begin
                  state <= DONE;
               end else if (take) begin
                  cur_addr <= i_desc_addr;
                  rem_len  <= i_desc_len;
                  cur_flow <= i_desc_flow;
                  state    <= READ;
               end
            end
            READ: begin
               cur_addr <= cur_addr + 1'b1;
               rem_len  <= rem_len - WB;
               if (beat_last) state <= ARMED;
            end
            DONE: begin
               batch_done <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   bram_rd_align #(.RD_LAT(RD_LAT)) u_align (
      .clk     (i_clk),
      .rst     (i_rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign o_bram_en          = (state == READ);
   assign o_bram_addr        = cur_addr;
   assign o_count_data       = tag_out.valid ? i_bram_dout : '0;
   assign o_count_data_valid = tag_out.valid;
   assign o_count_data_len   = tag_out.len;
   assign o_count_data_last  = tag_out.last;
   assign o_flow_num         = tag_out.flow;
   assign o_inflight         = inflight;
   assign o_batch_done       = batch_done;
   assign o_err              = err;

endmodule

// File: tb/tb_entropy_pkt_scheduler.sv
// Scoreboard bench for entropy_pkt_scheduler with a behavioural BRAM whose words encode
// their own address, so beat order and address wrap are both visible in the data.
module tb_entropy_pkt_scheduler;

   localparam int RD_LAT = 1;
   localparam int MAX_IF = 2;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_batch_start = 1'b0;
   logic [15:0] i_batch_pkts = '0;
   logic        i_desc_valid = 1'b0;
   logic        o_desc_ready;
   logic [15:0] i_desc_addr = '0;
   logic [7:0]  i_desc_len = '0;
   logic [15:0] i_desc_flow = '0;
   logic        o_bram_en;
   logic [15:0] o_bram_addr;
   logic [63:0] i_bram_dout;
   logic [63:0] o_count_data;
   logic        o_count_data_valid;
   logic [7:0]  o_count_data_len;
   logic        o_count_data_last;
   logic [15:0] o_flow_num;
   logic        i_result_valid = 1'b0;
   logic [3:0]  o_inflight;
   logic        o_batch_done;
   logic        o_err;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  len;
      logic        last;
      logic [15:0] flow;
   } beat_t;

   beat_t       exp_q [$];
   logic [15:0] addr_q [$];
   int          vectors = 0;
   int          miscompares = 0;

   always #5 i_clk = ~i_clk;

   entropy_pkt_scheduler #(
      .DATA_WIDTH(64), .ADDR_WIDTH(16), .RD_LAT(RD_LAT), .MAX_INFLIGHT(MAX_IF)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_batch_start(i_batch_start), .i_batch_pkts(i_batch_pkts),
      .i_desc_valid(i_desc_valid), .o_desc_ready(o_desc_ready),
      .i_desc_addr(i_desc_addr), .i_desc_len(i_desc_len), .i_desc_flow(i_desc_flow),
      .o_bram_en(o_bram_en), .o_bram_addr(o_bram_addr), .i_bram_dout(i_bram_dout),
      .o_count_data(o_count_data), .o_count_data_valid(o_count_data_valid),
      .o_count_data_len(o_count_data_len), .o_count_data_last(o_count_data_last),
      .o_flow_num(o_flow_num), .i_result_valid(i_result_valid),
      .o_inflight(o_inflight), .o_batch_done(o_batch_done), .o_err(o_err)
   );

   function automatic logic [63:0] word(input logic [15:0] a);
      return {a, a ^ 16'hBEEF, ~a, a + 16'h1357};
   endfunction

   logic [63:0] rd_pipe [RD_LAT];
   always @(posedge i_clk) begin
      rd_pipe[0] <= o_bram_en ? word(o_bram_addr) : 64'h0;
      for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign i_bram_dout = rd_pipe[RD_LAT-1];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge i_clk) begin
      beat_t e;
      if (o_bram_en) begin
         if (addr_q.size() == 0) check("extra_en", o_bram_en, 1'b0);
         else check("bram_addr", o_bram_addr, addr_q.pop_front());
      end
      if (o_count_data_valid) begin
         if (exp_q.size() == 0) begin
            check("extra_beat", o_count_data_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", o_count_data, e.data);
            check("beat_len", o_count_data_len, e.len);
            check("beat_last", o_count_data_last, e.last);
            check("beat_flow", o_flow_num, e.flow);
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic push_expect(input logic [15:0] addr, input logic [7:0] len,
                              input logic [15:0] flow);
      int          rem;
      logic [15:0] a;
      beat_t       b;
      rem = int'(len);
      a   = addr;
      while (rem > 0) begin
         b.data = word(a);
         b.len  = (rem > 8) ? 8'd8 : 8'(rem);
         b.last = (rem <= 8);
         b.flow = flow;
         exp_q.push_back(b);
         addr_q.push_back(a);
         a   = a + 16'd1;
         rem = rem - 8;
      end
   endtask

   task automatic start_batch(input logic [15:0] n);
      i_batch_start = 1'b1;
      i_batch_pkts  = n;
      tick();
      i_batch_start = 1'b0;
   endtask

   task automatic send_desc(input logic [15:0] addr, input logic [7:0] len,
                            input logic [15:0] flow, input bit with_res);
      bit accepted;
      accepted     = 1'b0;
      i_desc_valid = 1'b1;
      i_desc_addr  = addr;
      i_desc_len   = len;
      i_desc_flow  = flow;
      for (int i = 0; i < 40 && !accepted; i++) begin
         @(negedge i_clk);
         if (o_desc_ready) begin
            accepted = 1'b1;
            push_expect(addr, len, flow);
            if (with_res) i_result_valid = 1'b1;
         end
      end
      check("desc_handshake", accepted, 1'b1);
      tick();
      i_desc_valid   = 1'b0;
      i_result_valid = 1'b0;
   endtask

   task automatic pulse_result();
      i_result_valid = 1'b1;
      tick();
      i_result_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && (exp_q.size() != 0 || addr_q.size() != 0); i++)
         @(negedge i_clk);
      check("drain", exp_q.size() + addr_q.size(), 0);
      tick();
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge i_clk);
         seen = o_batch_done;
      end
      check("batch_done", seen, 1'b1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #3;
      check("rst_ready", o_desc_ready, 1'b0);
      check("rst_en", o_bram_en, 1'b0);
      check("rst_valid", o_count_data_valid, 1'b0);
      check("rst_inflight", o_inflight, 4'd0);
      check("rst_done", o_batch_done, 1'b0);
      check("rst_err", o_err, 1'b0);
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      tick();

      // Single packet, 20 bytes -> 8,8,4
      start_batch(16'd1);
      send_desc(16'h0010, 8'd20, 16'h0A01, 1'b0);
      check("t1_inflight", o_inflight, 4'd1);
      @(negedge i_clk);
      check("t1_first_en", o_bram_en, 1'b1);
      check("t1_no_early_valid", o_count_data_valid, 1'b0);
      @(negedge i_clk);
      check("t1_first_valid", o_count_data_valid, 1'b1);
      wait_drain(20);
      pulse_result();
      wait_done(6);
      check("t1_inflight_end", o_inflight, 4'd0);
      check("t1_err", o_err, 1'b0);

      // Address wrap at the top of the BRAM
      start_batch(16'd1);
      send_desc(16'hFFFF, 8'd16, 16'h0B02, 1'b0);
      wait_drain(20);
      pulse_result();
      wait_done(6);

      // Empty batch: done two cycles after the start strobe
      start_batch(16'd0);
      @(negedge i_clk);
      check("t5_done_c1", o_batch_done, 1'b0);
      @(negedge i_clk);
      check("t5_done_c2", o_batch_done, 1'b1);
      @(negedge i_clk);
      check("t5_done_c3", o_batch_done, 1'b0);
      tick();

      // Zero-length descriptor: dropped, flagged, counted retired
      start_batch(16'd1);
      send_desc(16'h0100, 8'd0, 16'h0C03, 1'b0);
      @(negedge i_clk);
      check("t5_len0_en", o_bram_en, 1'b0);
      check("t5_len0_inflight", o_inflight, 4'd0);
      check("t5_len0_err", o_err, 1'b1);
      wait_done(8);

      // Reset in the middle of a read burst
      start_batch(16'd1);
      send_desc(16'h0200, 8'd40, 16'h0D04, 1'b0);
      @(negedge i_clk);
      @(negedge i_clk);
      #2 i_rst = 1'b1;
      #1;
      check("t6_en", o_bram_en, 1'b0);
      check("t6_addr", o_bram_addr, 16'h0);
      check("t6_valid", o_count_data_valid, 1'b0);
      check("t6_data", o_count_data, 64'h0);
      check("t6_len_last_flow", {o_count_data_len, o_count_data_last, o_flow_num}, '0);
      check("t6_inflight", o_inflight, 4'd0);
      check("t6_err", o_err, 1'b0);
      exp_q.delete();
      addr_q.delete();
      tick();
      i_rst = 1'b0;
      tick();

      // Credit limit, then handshake and result in one cycle
      start_batch(16'd4);
      send_desc(16'h0040, 8'd8, 16'h0E10, 1'b0);
      send_desc(16'h0050, 8'd12, 16'h0E11, 1'b0);
      wait_drain(20);
      check("t2_ready_blocked", o_desc_ready, 1'b0);
      check("t2_inflight_max", o_inflight, 4'd2);
      pulse_result();
      send_desc(16'h0060, 8'd3, 16'h0E12, 1'b0);
      check("t2_inflight_after3", o_inflight, 4'd2);
      wait_drain(20);
      pulse_result();
      check("t3_inflight_pre", o_inflight, 4'd1);
      send_desc(16'h0070, 8'd16, 16'h0E13, 1'b1);
      check("t3_inflight_same", o_inflight, 4'd1);
      wait_drain(20);
      pulse_result();
      wait_done(8);
      check("t3_err_clean", o_err, 1'b0);
      pulse_result();
      @(negedge i_clk);
      check("t3_err_orphan", o_err, 1'b1);
      check("t3_inflight_zero", o_inflight, 4'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
